// File: rtl/dp_tcdm_rr_mux.sv
// rtl/dp_tcdm_rr_mux.sv - round-robin N-to-1 TCDM request mux with in-order response routing
//
// Ports:
//   clk_i, rst_ni                     clock, asynchronous active-low reset
//   in_req/in_gnt                     per-master request / zero-cycle grant
//   in_add/in_wen/in_be/in_data       flat per-master payload vectors (32/1/4/32 bits each)
//   in_r_data/in_r_valid              per-master response (data broadcast, valid steered)
//   out_req/out_gnt                   shared downstream request handshake
//   out_add/out_wen/out_be/out_data   downstream payload of the current winner
//   out_r_data/out_r_valid            downstream in-order response
//   err_o                             sticky: response seen with nothing outstanding
module dp_tcdm_rr_mux #(
    parameter int N_IN            = 4,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [N_IN-1:0]      in_req,
    output logic [N_IN-1:0]      in_gnt,
    input  logic [N_IN*32-1:0]   in_add,
    input  logic [N_IN-1:0]      in_wen,
    input  logic [N_IN*4-1:0]    in_be,
    input  logic [N_IN*32-1:0]   in_data,
    output logic [N_IN*32-1:0]   in_r_data,
    output logic [N_IN-1:0]      in_r_valid,
    output logic                 out_req,
    input  logic                 out_gnt,
    output logic [31:0]          out_add,
    output logic                 out_wen,
    output logic [3:0]           out_be,
    output logic [31:0]          out_data,
    input  logic [31:0]          out_r_data,
    input  logic                 out_r_valid,
    output logic                 err_o
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(MAX_OUTSTANDING);

    logic [IDX_W-1:0] ptr_q, ptr_d;
    logic             lock_valid_q, lock_valid_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic [IDX_W-1:0] fifo_q [MAX_OUTSTANDING];
    logic [IDX_W-1:0] fifo_d [MAX_OUTSTANDING];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;

    logic             any_req;
    logic             full;
    logic             empty;
    logic             rr_found;
    logic [IDX_W-1:0] rr_idx;
    logic             lock_hit;
    logic [IDX_W-1:0] win_idx;
    logic [IDX_W-1:0] head_idx;
    logic             accept;
    logic             pop;

    assign any_req  = |in_req;
    // Full is taken from the registered count only, so a same-cycle pop
    // cannot re-open the gate combinationally.
    assign full     = (count_q == CNT_FULL);
    assign empty    = (count_q == '0);
    assign head_idx = fifo_q[rd_ptr_q];

    // First requester scanning ptr, ptr+1, ... modulo N_IN.
    always_comb begin
        rr_found = 1'b0;
        rr_idx   = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (!rr_found && in_req[(int'(ptr_q) + i) % N_IN]) begin
                rr_found = 1'b1;
                rr_idx   = IDX_W'((int'(ptr_q) + i) % N_IN);
            end
        end
    end

    // A locked master keeps the port until granted; if it withdraws,
    // plain round-robin takes over in the same cycle.
    assign lock_hit = lock_valid_q && in_req[lock_idx_q];
    assign win_idx  = lock_hit ? lock_idx_q : rr_idx;

    // Reset gates the handshake outputs so they read idle while rst_ni is low.
    assign out_req   = rst_ni && any_req && !full;
    assign accept    = out_req && out_gnt;
    assign pop       = rst_ni && out_r_valid && !empty;
    assign in_r_data = rst_ni ? {N_IN{out_r_data}} : '0;
    assign err_o     = err_q;

    always_comb begin
        in_gnt     = '0;
        in_r_valid = '0;
        out_add    = '0;
        out_wen    = 1'b1;
        out_be     = '0;
        out_data   = '0;
        if (out_req) begin
            in_gnt[win_idx] = out_gnt;
            out_add         = in_add[32*int'(win_idx) +: 32];
            out_wen         = in_wen[win_idx];
            out_be          = in_be[4*int'(win_idx) +: 4];
            out_data        = in_data[32*int'(win_idx) +: 32];
        end
        if (pop) begin
            in_r_valid[head_idx] = 1'b1;
        end
    end

    always_comb begin
        ptr_d        = ptr_q;
        lock_valid_d = lock_valid_q;
        lock_idx_d   = lock_idx_q;
        fifo_d       = fifo_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        count_d      = count_q;
        err_d        = err_q | (rst_ni & out_r_valid & empty);

        if (accept) begin
            ptr_d = (int'(win_idx) == N_IN - 1) ? '0 : win_idx + 1'b1;
        end

        if (accept) begin
            lock_valid_d = 1'b0;
        end else if (out_req) begin
            lock_valid_d = 1'b1;
            lock_idx_d   = win_idx;
        end else if (!lock_hit) begin
            lock_valid_d = 1'b0;
        end

        if (accept) begin
            fifo_d[wr_ptr_q] = win_idx;
            wr_ptr_d         = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        case ({accept, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q        <= '0;
            lock_valid_q <= 1'b0;
            lock_idx_q   <= '0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_q[i] <= '0;
            end
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            err_q        <= 1'b0;
        end else begin
            ptr_q        <= ptr_d;
            lock_valid_q <= lock_valid_d;
            lock_idx_q   <= lock_idx_d;
            fifo_q       <= fifo_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            err_q        <= err_d;
        end
    end

endmodule

// File: tb/tb_dp_tcdm_rr_mux.sv
// tb/tb_dp_tcdm_rr_mux.sv - directed self-checking bench for dp_tcdm_rr_mux
module tb_dp_tcdm_rr_mux;

    localparam int N_IN = 4;
    localparam int MAX_OUTSTANDING = 4;

    logic                 clk_i = 1'b0;
    logic                 rst_ni;
    logic [N_IN-1:0]      in_req;
    logic [N_IN-1:0]      in_gnt;
    logic [N_IN*32-1:0]   in_add;
    logic [N_IN-1:0]      in_wen;
    logic [N_IN*4-1:0]    in_be;
    logic [N_IN*32-1:0]   in_data;
    logic [N_IN*32-1:0]   in_r_data;
    logic [N_IN-1:0]      in_r_valid;
    logic                 out_req;
    logic                 out_gnt;
    logic [31:0]          out_add;
    logic                 out_wen;
    logic [3:0]           out_be;
    logic [31:0]          out_data;
    logic [31:0]          out_r_data;
    logic                 out_r_valid;
    logic                 err_o;

    int checks = 0;
    int failures = 0;
    int exp_q[$];

    always #5 clk_i = ~clk_i;

    dp_tcdm_rr_mux #(.N_IN(N_IN), .MAX_OUTSTANDING(MAX_OUTSTANDING)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .in_req(in_req), .in_gnt(in_gnt), .in_add(in_add), .in_wen(in_wen),
        .in_be(in_be), .in_data(in_data), .in_r_data(in_r_data), .in_r_valid(in_r_valid),
        .out_req(out_req), .out_gnt(out_gnt), .out_add(out_add), .out_wen(out_wen),
        .out_be(out_be), .out_data(out_data), .out_r_data(out_r_data),
        .out_r_valid(out_r_valid), .err_o(err_o)
    );

    function automatic logic [31:0] addr_of(input int i);
        return 32'hA000_0000 + 32'(i) * 32'h10;
    endfunction

    function automatic logic [31:0] data_of(input int i);
        return 32'hD000_0000 + 32'(i);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One cycle: drive after the edge, check combinational outputs mid-cycle.
    // Expected issuer indices go into exp_q on acceptance and come back out
    // when a response is driven.
    task automatic step(input logic [3:0] req, input logic gnt, input logic rv,
                        input logic exp_oreq, input int exp_win, input string tag);
        logic [31:0] rdata;
        int          issuer;
        @(posedge clk_i);
        #1;
        rdata       = $urandom;
        in_req      = req;
        out_gnt     = gnt;
        out_r_valid = rv;
        out_r_data  = rdata;
        #3;
        chk({tag, ".out_req"}, 64'(out_req), 64'(exp_oreq));
        chk({tag, ".in_gnt"}, 64'(in_gnt),
            (exp_oreq && gnt) ? (64'd1 << exp_win) : 64'd0);
        if (exp_oreq) begin
            chk({tag, ".out_add"}, 64'(out_add), 64'(addr_of(exp_win)));
            chk({tag, ".out_wen"}, 64'(out_wen), 64'((exp_win % 2) == 1));
            chk({tag, ".out_be"}, 64'(out_be), 64'd1 << exp_win);
            chk({tag, ".out_data"}, 64'(out_data), 64'(data_of(exp_win)));
        end else begin
            chk({tag, ".idle_add"}, 64'(out_add), 64'd0);
            chk({tag, ".idle_wen"}, 64'(out_wen), 64'd1);
        end
        if (rv) begin
            if (exp_q.size() != 0) begin
                issuer = exp_q.pop_front();
                chk({tag, ".in_r_valid"}, 64'(in_r_valid), 64'd1 << issuer);
                chk({tag, ".in_r_data"}, 64'(in_r_data[issuer*32 +: 32]), 64'(rdata));
            end else begin
                chk({tag, ".no_r_valid"}, 64'(in_r_valid), 64'd0);
            end
        end else begin
            chk({tag, ".quiet_r_valid"}, 64'(in_r_valid), 64'd0);
        end
        if (exp_oreq && gnt) begin
            exp_q.push_back(exp_win);
        end
    endtask

    initial begin
        rst_ni      = 1'b0;
        in_req      = '0;
        out_gnt     = 1'b0;
        out_r_valid = 1'b0;
        out_r_data  = '0;
        for (int i = 0; i < N_IN; i++) begin
            in_add[i*32 +: 32]  = addr_of(i);
            in_data[i*32 +: 32] = data_of(i);
            in_be[i*4 +: 4]     = 4'(1 << i);
            in_wen[i]           = ((i % 2) == 1);
        end

        // Reset state
        @(posedge clk_i);
        #3;
        chk("rst.out_req", 64'(out_req), 64'd0);
        chk("rst.in_gnt", 64'(in_gnt), 64'd0);
        chk("rst.out_wen", 64'(out_wen), 64'd1);
        chk("rst.out_add", 64'(out_add), 64'd0);
        chk("rst.err_o", 64'(err_o), 64'd0);
        chk("rst.in_r_valid", 64'(in_r_valid), 64'd0);
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;

        // All inputs requesting, one-cycle responses: grants rotate 0..3
        for (int c = 0; c < 8; c++) begin
            step(4'hF, 1'b1, exp_q.size() != 0, 1'b1, c % 4, "rr_all");
        end
        step(4'h0, 1'b0, 1'b1, 1'b0, 0, "rr_drain");

        // Only input 2 requests: it wins every cycle, ptr parks at 3
        for (int c = 0; c < 3; c++) begin
            step(4'b0100, 1'b1, exp_q.size() != 0, 1'b1, 2, "solo2");
        end
        step(4'hF, 1'b1, 1'b1, 1'b1, 3, "solo2_ptr");
        step(4'h0, 1'b0, 1'b1, 1'b0, 0, "solo2_drain");

        // Lock: input 1 stalled, input 0 joins late but must wait
        step(4'b0010, 1'b0, 1'b0, 1'b1, 1, "lock_c0");
        step(4'b0010, 1'b0, 1'b0, 1'b1, 1, "lock_c1");
        step(4'b0011, 1'b0, 1'b0, 1'b1, 1, "lock_c2");
        step(4'b0011, 1'b1, 1'b0, 1'b1, 1, "lock_gnt");
        step(4'b0001, 1'b1, 1'b1, 1'b1, 0, "lock_next");
        step(4'h0, 1'b0, 1'b1, 1'b0, 0, "lock_drain");

        // Flow gate: four accepts fill the FIFO, a pop reopens it one cycle later
        for (int c = 0; c < 4; c++) begin
            step(4'b0001, 1'b1, 1'b0, 1'b1, 0, "fill");
        end
        step(4'b0001, 1'b1, 1'b0, 1'b0, 0, "full_block");
        step(4'b0001, 1'b1, 1'b1, 1'b0, 0, "full_pop");
        step(4'b0001, 1'b1, 1'b0, 1'b1, 0, "full_reopen");
        for (int c = 0; c < 4; c++) begin
            step(4'h0, 1'b0, 1'b1, 1'b0, 0, "full_drain");
        end
        chk("pre_err.err_o", 64'(err_o), 64'd0);

        // Stray response: err_o rises the next cycle and stays
        step(4'h0, 1'b0, 1'b1, 1'b0, 0, "stray");
        chk("stray.err_same_cycle", 64'(err_o), 64'd0);
        step(4'h0, 1'b0, 1'b0, 1'b0, 0, "stray_after");
        chk("stray.err_set", 64'(err_o), 64'd1);
        step(4'h0, 1'b0, 1'b0, 1'b0, 0, "stray_hold");
        chk("stray.err_sticky", 64'(err_o), 64'd1);

        // Reset with three transactions in flight
        for (int c = 0; c < 3; c++) begin
            step(4'b0001, 1'b1, 1'b0, 1'b1, 0, "inflight");
        end
        @(posedge clk_i);
        #1;
        in_req  = 4'hF;
        out_gnt = 1'b1;
        rst_ni  = 1'b0;
        #1;
        chk("midrst.out_req", 64'(out_req), 64'd0);
        chk("midrst.in_gnt", 64'(in_gnt), 64'd0);
        chk("midrst.out_wen", 64'(out_wen), 64'd1);
        chk("midrst.out_add", 64'(out_add), 64'd0);
        chk("midrst.err_o", 64'(err_o), 64'd0);
        exp_q.delete();
        in_req  = '0;
        out_gnt = 1'b0;
        @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        step(4'h0, 1'b0, 1'b1, 1'b0, 0, "post_rst_resp");
        step(4'h0, 1'b0, 1'b0, 1'b0, 0, "post_rst_idle");
        chk("post_rst.err_set", 64'(err_o), 64'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
